// File: rtl/i2c_pkg.sv
// Shared definitions for the I2C target: FSM state encoding and bus-level constants.
package i2c_pkg;

  typedef enum logic [3:0] {
    IDLE,
    ADDR,
    ADDR_ACK,
    REG,
    REG_ACK,
    WDATA,
    WDATA_ACK,
    RDATA,
    RACK
  } i2c_state_t;

  localparam logic I2C_RW_READ = 1'b1;
  localparam logic I2C_ACK     = 1'b0;

endpackage

// File: rtl/i2c_line_filter.sv
// Conditions one raw I2C pad input: 2-FF synchroniser followed by a stability filter.
// The filtered value only follows the input after FILTER_LEN consecutive differing
// samples; rise/fall are one-clk pulses coincident with the filtered value changing.
module i2c_line_filter #(
  parameter int unsigned FILTER_LEN = 3
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic filt,
  output logic rise,
  output logic fall
);

  localparam int unsigned CW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;

  logic          sync1;
  logic          sync2;
  logic [CW-1:0] cnt;

  // Two-stage synchroniser; idles high like the bus so reset creates no false edges.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
    end
  end

  // Stability filter: count consecutive samples that disagree with the filtered value.
  always_ff @(posedge clk) begin
    if (reset) begin
      filt <= 1'b1;
      cnt  <= '0;
      rise <= 1'b0;
      fall <= 1'b0;
    end else begin
      rise <= 1'b0;
      fall <= 1'b0;
      if (sync2 == filt) begin
        cnt <= '0;
      end else if (cnt == CW'(FILTER_LEN - 1)) begin
        filt <= sync2;
        cnt  <= '0;
        rise <= sync2;
        fall <= ~sync2;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/i2c_slave_regfile.sv
// I2C target with a 2**REG_AW byte register file, auto-incrementing pointer,
// write strobe to local logic and a registered host read port.
module i2c_slave_regfile
  import i2c_pkg::*;
#(
  parameter logic [6:0]  SLAVE_ADDR = 7'h69,
  parameter int unsigned REG_AW     = 4,
  parameter int unsigned FILTER_LEN = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              scl_i,
  input  logic              sda_i,
  output logic              sda_oe,
  output logic              busy,
  output logic              wr_stb,
  output logic [REG_AW-1:0] wr_addr,
  output logic [7:0]        wr_data,
  input  logic [REG_AW-1:0] host_rd_addr,
  output logic [7:0]        host_rd_data
);

  localparam int unsigned DEPTH = 2 ** REG_AW;

  logic scl, scl_rise, scl_fall;
  logic sda, sda_rise, sda_fall;
  logic start_det, stop_det;

  i2c_state_t        state;
  logic [3:0]        bit_cnt;
  logic [7:0]        shift_rx;
  logic [7:0]        shift_tx;
  logic [7:0]        rx_byte;
  logic [REG_AW-1:0] ptr;
  logic              rw;
  logic [7:0]        regs [DEPTH];

  i2c_line_filter #(.FILTER_LEN(FILTER_LEN)) u_scl_filter (
    .clk   (clk),
    .reset (reset),
    .raw   (scl_i),
    .filt  (scl),
    .rise  (scl_rise),
    .fall  (scl_fall)
  );

  i2c_line_filter #(.FILTER_LEN(FILTER_LEN)) u_sda_filter (
    .clk   (clk),
    .reset (reset),
    .raw   (sda_i),
    .filt  (sda),
    .rise  (sda_rise),
    .fall  (sda_fall)
  );

  // Bus conditions and the byte as it will look once the current bit is shifted in.
  always_comb begin
    start_det = sda_fall & scl;
    stop_det  = sda_rise & scl;
    rx_byte   = {shift_rx[6:0], sda};
  end

  // Protocol FSM, shift registers, pointer and register file writes.
  // In the three ACK states sda_oe doubles as the phase flag: first SCL fall
  // starts the ACK drive, the second one ends the ACK bit.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      bit_cnt  <= '0;
      shift_rx <= '0;
      shift_tx <= '0;
      ptr      <= '0;
      rw       <= 1'b0;
      sda_oe   <= 1'b0;
      busy     <= 1'b0;
      wr_stb   <= 1'b0;
      wr_addr  <= '0;
      wr_data  <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) regs[i] <= '0;
    end else begin
      wr_stb <= 1'b0;
      if (start_det) begin
        state   <= ADDR;
        bit_cnt <= '0;
        busy    <= 1'b1;
        sda_oe  <= 1'b0;
      end else if (stop_det) begin
        state  <= IDLE;
        busy   <= 1'b0;
        sda_oe <= 1'b0;
      end else begin
        case (state)
          IDLE: ;
          ADDR, REG, WDATA: begin
            if (scl_rise) begin
              shift_rx <= rx_byte;
              bit_cnt  <= bit_cnt + 1'b1;
              if (bit_cnt == 4'd7) begin
                if (state == ADDR) begin
                  if (rx_byte[7:1] == SLAVE_ADDR) begin
                    state <= ADDR_ACK;
                    rw    <= rx_byte[0];
                  end else begin
                    state <= IDLE;
                    busy  <= 1'b0;
                  end
                end else if (state == REG) begin
                  ptr   <= rx_byte[REG_AW-1:0];
                  state <= REG_ACK;
                end else begin
                  state <= WDATA_ACK;
                end
              end
            end
          end
          ADDR_ACK: begin
            if (scl_fall) begin
              if (!sda_oe) begin
                sda_oe <= 1'b1;
              end else begin
                bit_cnt <= '0;
                if (rw == I2C_RW_READ) begin
                  shift_tx <= regs[ptr];
                  sda_oe   <= ~regs[ptr][7];
                  state    <= RDATA;
                end else begin
                  sda_oe <= 1'b0;
                  state  <= REG;
                end
              end
            end
          end
          REG_ACK: begin
            if (scl_fall) begin
              if (!sda_oe) begin
                sda_oe <= 1'b1;
              end else begin
                sda_oe  <= 1'b0;
                bit_cnt <= '0;
                state   <= WDATA;
              end
            end
          end
          WDATA_ACK: begin
            if (scl_fall) begin
              if (!sda_oe) begin
                sda_oe    <= 1'b1;
                regs[ptr] <= shift_rx;
                wr_stb    <= 1'b1;
                wr_addr   <= ptr;
                wr_data   <= shift_rx;
                ptr       <= ptr + 1'b1;
              end else begin
                sda_oe  <= 1'b0;
                bit_cnt <= '0;
                state   <= WDATA;
              end
            end
          end
          // bit_cnt==0 on a fall means the byte was loaded at the RACK rise and
          // its MSB still has to be put on the bus.
          RDATA: begin
            if (scl_rise) begin
              bit_cnt <= bit_cnt + 1'b1;
            end else if (scl_fall) begin
              if (bit_cnt == 4'd8) begin
                sda_oe  <= 1'b0;
                bit_cnt <= '0;
                ptr     <= ptr + 1'b1;
                state   <= RACK;
              end else if (bit_cnt == 4'd0) begin
                sda_oe <= ~shift_tx[7];
              end else begin
                shift_tx <= {shift_tx[6:0], 1'b0};
                sda_oe   <= ~shift_tx[6];
              end
            end
          end
          RACK: begin
            if (scl_rise) begin
              if (sda == I2C_ACK) begin
                shift_tx <= regs[ptr];
                bit_cnt  <= '0;
                state    <= RDATA;
              end else begin
                state <= IDLE;
                busy  <= 1'b0;
              end
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  // Host read port; a same-clk I2C write to the same index returns the old value.
  always_ff @(posedge clk) begin
    if (reset) host_rd_data <= '0;
    else       host_rd_data <= regs[host_rd_addr];
  end

endmodule
